// File: rtl/deca_pkg.sv
// Shared definitions for the deca fetch/sequencer slice: fetch FSM states,
// opcode field positions and default datapath widths.
package deca_pkg;

    localparam int DEFAULT_ADDR_W = 8;
    localparam int DEFAULT_DATA_W = 16;

    // Opcode occupies the top nibble; its MSB flags a two-execute-cycle instruction.
    localparam int OPC_MSB   = DEFAULT_DATA_W - 1;
    localparam int OPC_LSB   = DEFAULT_DATA_W - 4;
    localparam int EXTRA_BIT = OPC_MSB;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_pf_buf.sv
// One-entry prefetch buffer: data register, valid bit and a discard flag that
// marks an in-flight prefetch whose data must be dropped after a jump.
module fetch_pf_buf #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr,
    input  logic              arm_discard,
    input  logic              disarm,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              discard
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid   <= 1'b0;
            data    <= '0;
            discard <= 1'b0;
        end else begin
            if (clr) begin
                valid <= 1'b0;
            end else if (wr_en) begin
                valid <= 1'b1;
            end
            if (wr_en) begin
                data <= wr_data;
            end
            // The ack of the discarded read ends the discard window, even if a jump lands alongside it.
            if (disarm) begin
                discard <= 1'b0;
            end else if (arm_discard) begin
                discard <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, IR and a req/ack read port, supplying EXTRA and P
// to the sequencer. Optional one-entry prefetch is enabled with FETCH_PREFETCH_EN.
module fetch_unit
    import deca_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FETCH,
    input  logic              EXEC1,
    input  logic              EXEC2,
    input  logic              JUMP,
    input  logic [ADDR_W-1:0] JUMP_ADDR,
    output logic              MEM_REQ,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic              MEM_ACK,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic [DATA_W-1:0] IR,
    output logic [ADDR_W-1:0] PC,
    output logic              EXTRA,
    output logic              P
);

    fetch_state_e      state_q, state_d;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] ir_q;
    logic              jump_ok;
    logic              start_req;
    logic              load_ir_mem;
    logic              inc_pc;

    assign jump_ok = JUMP && (EXEC1 || EXEC2);

`ifdef FETCH_PREFETCH_EN
    logic              pf_q;      // outstanding request is a prefetch
    logic              pf_arm_q;  // IR loaded since last prefetch issue
    logic              start_pf;
    logic              load_ir_buf;
    logic              buf_wr;
    logic              buf_valid;
    logic              buf_discard;
    logic [DATA_W-1:0] buf_data;

    fetch_pf_buf #(.DATA_W(DATA_W)) u_pf_buf (
        .clk         (CLK),
        .reset       (RESET),
        .wr_en       (buf_wr),
        .wr_data     (MEM_RDATA),
        .clr         (jump_ok || load_ir_buf),
        .arm_discard (jump_ok && pf_q && (state_q == REQ)),
        .disarm      ((state_q == REQ) && MEM_ACK && pf_q),
        .valid       (buf_valid),
        .data        (buf_data),
        .discard     (buf_discard)
    );

    assign P = mem_req_q || (FETCH && (state_q == IDLE) && !buf_valid);
`else
    assign P = mem_req_q || (FETCH && (state_q == IDLE));
`endif

    always_comb begin
        state_d     = state_q;
        start_req   = 1'b0;
        load_ir_mem = 1'b0;
        inc_pc      = 1'b0;
`ifdef FETCH_PREFETCH_EN
        start_pf    = 1'b0;
        load_ir_buf = 1'b0;
        buf_wr      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
`ifdef FETCH_PREFETCH_EN
                if (FETCH && buf_valid) begin
                    load_ir_buf = 1'b1;
                end else if (FETCH) begin
                    start_req = 1'b1;
                    state_d   = REQ;
                end else if (pf_arm_q && (EXEC1 || EXEC2) && !jump_ok) begin
                    start_req = 1'b1;
                    start_pf  = 1'b1;
                    state_d   = REQ;
                end
`else
                if (FETCH) begin
                    start_req = 1'b1;
                    state_d   = REQ;
                end
`endif
            end
            REQ: begin
                if (MEM_ACK) begin
                    state_d = IDLE;
`ifdef FETCH_PREFETCH_EN
                    // A prefetch ack feeds IR directly if the sequencer is already waiting in FETCH.
                    if (!pf_q) begin
                        load_ir_mem = 1'b1;
                        inc_pc      = 1'b1;
                    end else if (!buf_discard && !jump_ok) begin
                        inc_pc = 1'b1;
                        if (FETCH) begin
                            load_ir_mem = 1'b1;
                        end else begin
                            buf_wr = 1'b1;
                        end
                    end
`else
                    load_ir_mem = 1'b1;
                    inc_pc      = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            pc_q       <= '0;
            ir_q       <= '0;
        end else begin
            state_q <= state_d;
            if (start_req) begin
                mem_req_q  <= 1'b1;
                mem_addr_q <= pc_q;
            end else if ((state_q == REQ) && MEM_ACK) begin
                mem_req_q <= 1'b0;
            end
            if (load_ir_mem) begin
                ir_q <= MEM_RDATA;
`ifdef FETCH_PREFETCH_EN
            end else if (load_ir_buf) begin
                ir_q <= buf_data;
`endif
            end
            // A resolved jump overrides any increment in the same cycle.
            if (jump_ok) begin
                pc_q <= JUMP_ADDR;
            end else if (inc_pc) begin
                pc_q <= pc_q + ADDR_W'(1);
            end
        end
    end

`ifdef FETCH_PREFETCH_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pf_q     <= 1'b0;
            pf_arm_q <= 1'b0;
        end else begin
            if (start_req) begin
                pf_q <= start_pf;
            end
            if (load_ir_mem || load_ir_buf) begin
                pf_arm_q <= 1'b1;
            end else if (start_pf) begin
                pf_arm_q <= 1'b0;
            end
        end
    end
`endif

    assign MEM_REQ  = mem_req_q;
    assign MEM_ADDR = mem_addr_q;
    assign IR       = ir_q;
    assign PC       = pc_q;
    assign EXTRA    = ir_q[DATA_W-1];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: acts as instruction memory and sequencer, checking
// against a transaction-level model of PC/IR and fetch timing.
module tb_fetch_unit;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch, exec1, exec2, jump;
  logic [AW-1:0] jump_addr;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] ir;
  logic [AW-1:0] pc;
  logic          extra;
  logic          p;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] m_pc;
  logic [DW-1:0] m_ir;
  logic [AW-1:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(clk), .RESET(reset), .FETCH(fetch), .EXEC1(exec1), .EXEC2(exec2),
    .JUMP(jump), .JUMP_ADDR(jump_addr), .MEM_REQ(mem_req), .MEM_ADDR(mem_addr),
    .MEM_ACK(mem_ack), .MEM_RDATA(mem_rdata), .IR(ir), .PC(pc), .EXTRA(extra), .P(p)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    fetch = 1'b0; exec1 = 1'b0; exec2 = 1'b0; jump = 1'b0;
    jump_addr = '0; mem_ack = 1'b0; mem_rdata = DW'($urandom);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_pc"}, 32'(pc), 32'(m_pc));
    check({tag, "_ir"}, 32'(ir), 32'(m_ir));
    check({tag, "_extra"}, 32'(extra), 32'(m_ir[DW-1]));
  endtask

  task automatic reset_dut();
    @(negedge clk); idle_inputs(); reset = 1'b1;
    @(negedge clk);
    @(negedge clk); reset = 1'b0; #1;
    m_pc = '0; m_ir = '0; exp_q.delete();
    check_model("rst");
    check("rst_req", 32'(mem_req), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_p", 32'(p), 0);
  endtask

  // Demand fetch: memory acks after 'waits' extra REQ cycles; optional ignored jump.
  task automatic do_fetch(input int waits, input logic [DW-1:0] data, input bit jump_noise);
    int p_cnt = 0;
    int req_cnt = 0;
    bit acked = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    exp_q.push_back(m_pc);
    @(negedge clk); idle_inputs(); fetch = 1'b1;
    if (jump_noise) begin
      jump = 1'b1; jump_addr = AW'($urandom);
    end
    for (int c = 0; c < 40 && !acked; c++) begin
      if (c > 0) begin
        @(negedge clk); jump = 1'b0;
      end
      if (mem_req) begin
        if (req_cnt == 0) begin
          if (exp_q.size() == 0) check("spurious_req", 1, 0);
          else exp_addr = exp_q.pop_front();
        end
        req_cnt++;
        check("mem_addr", 32'(mem_addr), 32'(exp_addr));
        if (req_cnt == waits + 1) begin
          mem_ack = 1'b1; mem_rdata = data; acked = 1'b1;
        end
      end
      #1;
      if (p) p_cnt++;
    end
    if (!acked) check("fetch_timeout", 0, 1);
    @(negedge clk); idle_inputs(); #1;
    m_ir = data;
    m_pc = m_pc + 1'b1;
    check_model("fetch");
    check("fetch_p_after", 32'(p), 0);
    check("fetch_req_after", 32'(mem_req), 0);
    check("fetch_p_cycles", 32'(p_cnt), 32'(waits + 2));
    check("fetch_req_cycles", 32'(req_cnt), 32'(waits + 1));
  endtask

  task automatic do_jump(input logic [AW-1:0] a, input bit use_exec2);
    @(negedge clk); idle_inputs();
    if (use_exec2) exec2 = 1'b1; else exec1 = 1'b1;
    jump = 1'b1; jump_addr = a;
    @(negedge clk); idle_inputs(); #1;
    m_pc = a;
    check("jump_pc", 32'(pc), 32'(m_pc));
  endtask

  task automatic stray_jump();
    @(negedge clk); idle_inputs(); jump = 1'b1; jump_addr = AW'($urandom);
    @(negedge clk); idle_inputs(); #1;
    check("stray_jump_pc", 32'(pc), 32'(m_pc));
    check("stray_jump_req", 32'(mem_req), 0);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    reset_dut();
`ifdef FETCH_PREFETCH_EN
    do_fetch(0, 16'h1234, 1'b0);
    @(negedge clk); idle_inputs(); exec1 = 1'b1;
    @(negedge clk); #1;
    check("pf_req", 32'(mem_req), 1);
    check("pf_addr", 32'(mem_addr), 32'(m_pc));
    mem_ack = 1'b1; mem_rdata = 16'hA55A;
    @(negedge clk); idle_inputs(); #1;
    m_pc = m_pc + 1'b1;
    check_model("pf_done");
    check("pf_req_done", 32'(mem_req), 0);
    @(negedge clk); fetch = 1'b1; #1;
    check("hit_p", 32'(p), 0);
    @(negedge clk); idle_inputs(); #1;
    m_ir = 16'hA55A;
    check_model("hit");
    check("hit_req", 32'(mem_req), 0);
    check("hit_p_after", 32'(p), 0);
    // Prefetch at PC=2, then jump while it is in flight.
    @(negedge clk); idle_inputs(); exec1 = 1'b1;
    @(negedge clk); idle_inputs(); exec1 = 1'b1; jump = 1'b1; jump_addr = 8'h40; #1;
    check("pf2_req", 32'(mem_req), 1);
    check("pf2_addr", 32'(mem_addr), 32'(m_pc));
    @(negedge clk); idle_inputs(); mem_ack = 1'b1; mem_rdata = 16'hDEAD; #1;
    m_pc = 8'h40;
    check("pf2_jump_pc", 32'(pc), 32'(m_pc));
    @(negedge clk); idle_inputs(); #1;
    check_model("pf2_discard");
    do_fetch(0, 16'h0777, 1'b0);
    // FETCH arrives while a prefetch is outstanding: its ack loads IR directly.
    @(negedge clk); idle_inputs(); exec2 = 1'b1;
    @(negedge clk); idle_inputs(); fetch = 1'b1; #1;
    check("pf3_addr", 32'(mem_addr), 32'(m_pc));
    check("pf3_p_wait", 32'(p), 1);
    @(negedge clk); fetch = 1'b1; mem_ack = 1'b1; mem_rdata = 16'h8ABC; #1;
    check("pf3_p_ack", 32'(p), 1);
    @(negedge clk); idle_inputs(); #1;
    m_ir = 16'h8ABC; m_pc = m_pc + 1'b1;
    check_model("pf3");
    check("pf3_p_after", 32'(p), 0);
`else
    do_fetch(0, 16'h1234, 1'b0);
    do_fetch(3, 16'h8001, 1'b0);
    do_jump(8'hFF, 1'b0);
    do_fetch(1, DW'($urandom), 1'b0);
    do_jump(8'h40, 1'b1);
    do_fetch(0, 16'h4321, 1'b0);
    do_fetch(2, DW'($urandom), 1'b1);
    stray_jump();
    // Reset while a request is outstanding.
    @(negedge clk); idle_inputs(); fetch = 1'b1;
    @(negedge clk); idle_inputs(); #1;
    check("midreq_req", 32'(mem_req), 1);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0; #1;
    m_pc = '0; m_ir = '0;
    check_model("midreq_rst");
    check("midreq_rst_req", 32'(mem_req), 0);
    check("midreq_rst_p", 32'(p), 0);
    check("midreq_rst_addr", 32'(mem_addr), 0);
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    @(negedge clk); idle_inputs(); #1;
    check_model("late_ack");
    do_fetch(0, 16'h0F0F, 1'b0);
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: do_jump(AW'($urandom), 1'($urandom_range(0, 1)));
        1: stray_jump();
        default: do_fetch($urandom_range(0, 4), DW'($urandom), 1'($urandom_range(0, 1)));
      endcase
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the control state machine. Holds the program counter and instruction register and runs a request/acknowledge read on instruction memory whenever the sequencer is in FETCH. It supplies the sequencer's two condition inputs: EXTRA (the instruction needs a second execute cycle) and P (a fetch is pending, so stall). It also accepts jumps resolved during execute.

## Interface
Parameters:
- ADDR_W, 8, program counter / memory address width
- DATA_W, 16, instruction width; opcode = IR[DATA_W-1:DATA_W-4]

Ports:
- CLK  in  1  sole clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- FETCH  in  1  sequencer decode: fetch state
- EXEC1  in  1  sequencer decode: first execute state
- EXEC2  in  1  sequencer decode: second execute state
- JUMP  in  1  load PC from JUMP_ADDR; honoured only when EXEC1|EXEC2
- JUMP_ADDR  in  ADDR_W  jump target
- MEM_REQ  out  1  read request, registered
- MEM_ADDR  out  ADDR_W  read address, registered, stable while MEM_REQ=1
- MEM_ACK  in  1  read complete; MEM_RDATA valid this cycle only
- MEM_RDATA  in  DATA_W  read data
- IR  out  DATA_W  instruction register
- PC  out  ADDR_W  address of next instruction to fetch
- EXTRA  out  1  IR[DATA_W-1]; two-execute-cycle instruction
- P  out  1  fetch pending (stall)

## Operation
- Internal FSM, two states:
  - IDLE: no memory transaction.
  - REQ: MEM_REQ=1, waiting for MEM_ACK.
- IDLE→REQ when FETCH=1 and IR has no buffered successor; that cycle MEM_ADDR<=PC and MEM_REQ<=1.
- REQ→IDLE on MEM_ACK=1: IR<=MEM_RDATA, PC<=PC+1 mod 2^ADDR_W (0xFF→0x00 for ADDR_W=8), MEM_REQ<=0.
- MEM_ACK seen in IDLE is ignored.
- P is combinational: P = MEM_REQ | (FETCH & state==IDLE & !buffer hit). The sequencer therefore stalls from the first FETCH cycle until the IR load.
- EXTRA is combinational from IR[DATA_W-1]. It is 0 after reset.
- JUMP with (EXEC1|EXEC2): PC<=JUMP_ADDR.
- JUMP outside execute is ignored.
- A jump in the same cycle as a PC increment (only possible with prefetch) wins; the increment is dropped.
- RESET at any cycle, including mid-REQ: state=IDLE, MEM_REQ=0, MEM_ADDR=0, PC=0, IR=0, EXTRA=0, P=0, prefetch buffer empty. The bench deasserts a pending MEM_ACK; an ack arriving after reset is ignored.

## Timing
- Minimum fetch latency with MEM_ACK in the first REQ cycle:
  - cycle t: FETCH, P=1
  - t+1: MEM_REQ=1, ack
  - t+2: IR/PC updated, P=0
- Each extra wait cycle adds one cycle to P.
- MEM_REQ stays high until MEM_ACK, with no timeout. MEM_ADDR does not change while MEM_REQ=1.
- JUMP takes effect on PC at the next edge. A FETCH in the following cycle uses the new PC.

## Configuration
- FETCH_PREFETCH_EN defined:
  - One-entry prefetch buffer. After an IR load, during EXEC1/EXEC2 the FSM issues a read at PC into the buffer; on ack, PC increments and the buffer is marked valid.
  - On the next FETCH with a valid buffer: IR<=buffer in one cycle, P=0 throughout, no MEM_REQ, buffer cleared.
  - JUMP clears the buffer and sets PC<=JUMP_ADDR. If a prefetch is outstanding, it completes on the bus but its data is discarded and PC is not incremented.
  - A FETCH arriving while a prefetch is outstanding waits on that ack (P=1), which then loads IR directly.
- Undefined: no buffer; memory is accessed only from FETCH as described above.

## Structure
- Shared package deca_pkg holds:
  - the fetch FSM state enum (IDLE, REQ)
  - opcode field position constants (OPC_MSB, OPC_LSB, EXTRA_BIT)
  - default widths ADDR_W/DATA_W
- One sub-module, fetch_pf_buf: data register, valid bit, discard flag. It is instantiated only under FETCH_PREFETCH_EN.

## Test plan
- Reset then FETCH with ack after 0 wait cycles, RDATA=0x1234 → MEM_ADDR=0x00; IR=0x1234, PC=0x01, EXTRA=0, P high exactly 2 cycles.
- FETCH with ack after 3 wait cycles, RDATA=0x8001 → MEM_REQ high 4 cycles, MEM_ADDR stable, EXTRA=1 after load, P high 5 cycles.
- PC=0xFF, fetch completes → PC=0x00.
- JUMP=1, JUMP_ADDR=0x40 during EXEC1, then FETCH → MEM_ADDR=0x40; JUMP during FETCH → PC unchanged.
- RESET asserted mid-REQ with MEM_REQ=1 → next cycle MEM_REQ=0, PC=0, IR=0, P=0; next FETCH addresses 0x00.
- FETCH_PREFETCH_EN: after first fetch, prefetch of 0x01 acked during EXEC1; next FETCH → IR loaded in one cycle, no MEM_REQ, P=0, PC=0x02. JUMP while prefetch outstanding → stale data discarded, PC=JUMP_ADDR.
